conv_window_scheduler16: RTL and testbench
==========================================

Name: conv_window_scheduler16

Overview:
Sequences one fp16 multiply-accumulate processing element over a full stride-1 valid convolution of one feature-map channel with one kernel.
- Generates read addresses for the feature-map buffer and the weight buffer, both synchronous RAMs with 1-cycle read latency.
- Streams operand pairs into the PE with the PE's conv_en timing.
- Captures each PE result and writes it to the output buffer in row-major order.
- Sits between the layer controller (start/done) and the PE/buffer datapath.

Parameters:
data_width, 16, fp16 operand/result width
weight_length, 3, kernel rows (K_L)
weight_width, 3, kernel columns (K_W)
img_height, 8, feature-map rows (H)
img_width, 8, feature-map columns (W)
addr_width, 8, address width for the fmap, weight and output buffers; must cover H*W-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request to run a convolution; ignored while busy
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the final output write
fmap_rd_en  out  1  feature-map read strobe
fmap_addr  out  addr_width  feature-map read address
fmap_data  in  data_width  feature-map read data, valid 1 cycle after fmap_rd_en
weight_rd_en  out  1  weight read strobe
weight_addr  out  addr_width  weight read address
weight_data  in  data_width  weight read data, valid 1 cycle after weight_rd_en
pe_floatA  out  data_width  PE operand A (pixel)
pe_floatB  out  data_width  PE operand B (weight)
pe_conv_en  out  1  PE enable
pe_result  in  data_width  PE accumulated result
pe_out_valid  in  1  PE result valid
out_we  out  1  output buffer write enable
out_addr  out  addr_width  output buffer address
out_data  out  data_width  output buffer write data

Behaviour:
- Sizes: OH = H-K_L+1, OW = W-K_W+1, S = K_L*K_W. Each window uses S+1 slots: slots 0..S-1 are reads, slot S is the gap.
- States: IDLE -> RUN on start; RUN -> FLUSH after the gap slot of the last window; FLUSH -> DONE on the last out_we; DONE -> IDLE after 1 cycle.
- Reset (reset==0, synchronous) from any state:
  - state goes to IDLE and all counters clear;
  - busy, done, fmap_rd_en, weight_rd_en, pe_conv_en and out_we go to 0;
  - addresses, operands and out_data go to 0.
  - A window cut off mid-way is discarded and no write is issued.
- RUN, per slot (kr, kc) with kr<K_L, kc<K_W, slot index kr*K_W+kc:
  - fmap_rd_en = weight_rd_en = 1;
  - fmap_addr = (row+kr)*W + (col+kc);
  - weight_addr = kr*K_W + kc.
- Gap slot: both read enables are 0.
- Window order: col increments from 0 to OW-1, then row increments from 0 to OH-1. Windows run back-to-back with no extra idle cycles.
- PE feed: pe_conv_en is registered "slot active" (read or gap slot), 1 cycle after the slot.
  - pe_floatA/pe_floatB equal fmap_data/weight_data (combinational pass-through, aligned with pe_conv_en).
  - During the gap slot both operands are 0x0000.
  - pe_conv_en stays high continuously for OH*OW*(S+1) cycles. This lets the PE wrap its internal count (S-1 -> S -> 0) between windows.
- Capture, registered: when pe_out_valid=1, next cycle out_we=1, out_data=pe_result, out_addr=out_cnt, and out_cnt increments.
  - out_cnt runs 0..OH*OW-1.
  - Window n's write occurs at cycle t0 + n*(S+1) + S + 2, where t0 is the first read slot.
- done: asserted the cycle after the write with out_cnt==OH*OW-1. busy falls in the same cycle done rises.
- Timing from start:
  - start sampled high in IDLE means the first read slot is the next cycle, and busy=1 that cycle.
  - start while busy or in DONE is ignored.
- pe_out_valid outside RUN/FLUSH is ignored (no write).
- Counter wrap: kc wraps at K_W-1, kr at K_L-1, col at OW-1, row at OH-1; each wrap is a carry into the next counter. No counter overflows addr_width for legal parameters.

Decomposition:
- Package conv16_pkg:
  - state encoding (IDLE/RUN/FLUSH/DONE);
  - localparams FP16_ZERO = 16'h0000, FP16_ONE = 16'h3C00;
  - functions computing OH, OW, S.
- One sub-module, conv_addr_gen16: the kr/kc/col/row counter chain. It outputs fmap_addr, weight_addr, rd_en, gap and last_window. The top holds the FSM, PE alignment registers and output capture.

Test Plan:
- H=W=4, K=3, all pixels and weights 0x3C00, start -> exactly 4 out_we pulses 10 cycles apart, out_addr 0,1,2,3, out_data 0x4880 (9.0) each; done one cycle after the 4th write.
- H=W=4, K=3, window 0 -> fmap_addr sequence 0,1,2,4,5,6,8,9,10, then a gap; weight_addr 0..8. Window 3 (row1,col1) -> 5,6,7,9,10,11,13,14,15.
- Weights all 0 except index 4 = 0x4000 (2.0), pixel p = 1.0*(p+1) -> each output equals 2 × centre pixel; window 0 gives 12.0 = 0x4A00.
- start pulsed again at cycle 5 of a run -> ignored; write count and addresses unchanged; pe_conv_en has no glitch.
- reset low for 1 cycle mid-window 2 -> all outputs 0 next cycle and no further out_we. A new start then yields a full fresh run from out_addr 0.
- H=8, W=8, K=3 defaults -> 36 writes, pe_conv_en high for exactly 360 consecutive cycles, done once.

Source files
------------

// File: rtl/conv16_pkg.sv
// Shared types, constants and size helpers for the fp16 convolution window scheduler.
package conv16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    // Output height/width of a stride-1 valid convolution, and window size in taps.
    function automatic int out_h(input int h, input int kl);
        return h - kl + 1;
    endfunction

    function automatic int out_w(input int w, input int kw);
        return w - kw + 1;
    endfunction

    function automatic int slots(input int kl, input int kw);
        return kl * kw;
    endfunction

endpackage

// File: rtl/conv_addr_gen16.sv
// kc -> kr -> gap -> col -> row counter chain; turns the current slot into fmap/weight read addresses.
module conv_addr_gen16
    import conv16_pkg::*;
#(
    parameter int weight_length = 3,
    parameter int weight_width  = 3,
    parameter int img_height    = 8,
    parameter int img_width     = 8,
    parameter int addr_width    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_run,
    output logic [addr_width-1:0] o_fmap_addr,
    output logic [addr_width-1:0] o_weight_addr,
    output logic                  o_rd_en,
    output logic                  o_gap,
    output logic                  o_last_window
);

    localparam int AW = addr_width;
    localparam int OH = out_h(img_height, weight_length);
    localparam int OW = out_w(img_width, weight_width);

    localparam logic [AW-1:0] KC_MAX  = AW'(weight_width - 1);
    localparam logic [AW-1:0] KR_MAX  = AW'(weight_length - 1);
    localparam logic [AW-1:0] COL_MAX = AW'(OW - 1);
    localparam logic [AW-1:0] ROW_MAX = AW'(OH - 1);

    logic [AW-1:0] r_kc;
    logic [AW-1:0] r_kr;
    logic [AW-1:0] r_col;
    logic [AW-1:0] r_row;
    logic          r_gap;

    // The gap slot sits between kr and col in the carry chain, so each window takes K_L*K_W+1 cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_kc  <= '0;
            r_kr  <= '0;
            r_col <= '0;
            r_row <= '0;
            r_gap <= 1'b0;
        end else if (i_run) begin
            if (r_gap) begin
                r_gap <= 1'b0;
                if (r_col == COL_MAX) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_MAX) ? '0 : r_row + AW'(1);
                end else begin
                    r_col <= r_col + AW'(1);
                end
            end else if (r_kc == KC_MAX) begin
                r_kc <= '0;
                if (r_kr == KR_MAX) begin
                    r_kr  <= '0;
                    r_gap <= 1'b1;
                end else begin
                    r_kr <= r_kr + AW'(1);
                end
            end else begin
                r_kc <= r_kc + AW'(1);
            end
        end
    end

    assign o_fmap_addr   = (r_row + r_kr) * AW'(img_width) + r_col + r_kc;
    assign o_weight_addr = r_kr * AW'(weight_width) + r_kc;
    assign o_rd_en       = i_run && !r_gap;
    assign o_gap         = r_gap;
    assign o_last_window = (r_row == ROW_MAX) && (r_col == COL_MAX);

endmodule

// File: rtl/conv_window_scheduler16.sv
// Drives one fp16 MAC PE across a full valid convolution: buffer reads, PE feed, result write-back.
module conv_window_scheduler16
    import conv16_pkg::*;
#(
    parameter int data_width    = 16,
    parameter int weight_length = 3,
    parameter int weight_width  = 3,
    parameter int img_height    = 8,
    parameter int img_width     = 8,
    parameter int addr_width    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fmap_rd_en,
    output logic [addr_width-1:0] fmap_addr,
    input  logic [data_width-1:0] fmap_data,
    output logic                  weight_rd_en,
    output logic [addr_width-1:0] weight_addr,
    input  logic [data_width-1:0] weight_data,
    output logic [data_width-1:0] pe_floatA,
    output logic [data_width-1:0] pe_floatB,
    output logic                  pe_conv_en,
    input  logic [data_width-1:0] pe_result,
    input  logic                  pe_out_valid,
    output logic                  out_we,
    output logic [addr_width-1:0] out_addr,
    output logic [data_width-1:0] out_data
);

    localparam int DW    = data_width;
    localparam int AW    = addr_width;
    localparam int N_WIN = out_h(img_height, weight_length) * out_w(img_width, weight_width);

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_pe_conv_en;
    logic          r_gap_d;
    logic          r_out_we;
    logic [AW-1:0] r_out_addr;
    logic [AW-1:0] r_out_cnt;
    logic [DW-1:0] r_out_data;

    logic          w_run;
    logic          w_rd_en;
    logic          w_gap;
    logic          w_last_window;
    logic          w_capture;
    logic          w_last_write;
    logic          w_feed;

    assign w_run = (r_state == ST_RUN);

    conv_addr_gen16 #(
        .weight_length(weight_length),
        .weight_width (weight_width),
        .img_height   (img_height),
        .img_width    (img_width),
        .addr_width   (addr_width)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .i_run        (w_run),
        .o_fmap_addr  (fmap_addr),
        .o_weight_addr(weight_addr),
        .o_rd_en      (w_rd_en),
        .o_gap        (w_gap),
        .o_last_window(w_last_window)
    );

    assign w_capture    = pe_out_valid && ((r_state == ST_RUN) || (r_state == ST_FLUSH));
    assign w_last_write = r_out_we && (r_out_addr == AW'(N_WIN - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pe_conv_en <= 1'b0;
            r_gap_d      <= 1'b0;
            r_out_we     <= 1'b0;
            r_out_addr   <= '0;
            r_out_cnt    <= '0;
            r_out_data   <= '0;
        end else begin
            // Delay slot-active/gap by one cycle so they line up with the RAMs' 1-cycle read data.
            r_pe_conv_en <= w_run;
            r_gap_d      <= w_gap;
            r_out_we     <= w_capture;
            r_done       <= 1'b0;

            if (w_capture) begin
                r_out_addr <= r_out_cnt;
                r_out_data <= pe_result;
                r_out_cnt  <= r_out_cnt + AW'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                        r_out_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_gap && w_last_window) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (w_last_write) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: operands are forced to zero whenever the PE is not fed real data, so stale RAM output never leaks out.
    assign w_feed    = r_pe_conv_en && !r_gap_d;
    assign pe_floatA = w_feed ? fmap_data   : DW'(FP16_ZERO);
    assign pe_floatB = w_feed ? weight_data : DW'(FP16_ZERO);

    assign busy         = r_busy;
    assign done         = r_done;
    assign fmap_rd_en   = w_rd_en;
    assign weight_rd_en = w_rd_en;
    assign pe_conv_en   = r_pe_conv_en;
    assign out_we       = r_out_we;
    assign out_addr     = r_out_addr;
    assign out_data     = r_out_data;

endmodule

// File: tb/tb_conv_window_scheduler16.sv
// Scoreboard bench: a 4x4 and a default 8x8 scheduler share behavioural RAMs and each drive a behavioural PE.
module tb_conv_window_scheduler16;
    import conv16_pkg::*;

    localparam int S = 9;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [7:0] faddr;
        logic [7:0] waddr;
        int         cyc;
    } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] fmem [0:63];
    logic [15:0] wmem [0:8];

    // ---------------- DUT with a 4x4 feature map ----------------
    logic        start4 = 1'b0, inj4 = 1'b0;
    logic        busy4, done4, frd4, wrd4, cen4, owe4;
    logic [7:0]  faddr4, waddr4, oaddr4;
    logic [15:0] fdata4 = '0, wdata4 = '0, fa4, fb4, odata4;
    logic [15:0] res4 = '0;
    logic        v4 = 1'b0;
    int          cnt4 = 0;
    real         acc4 = 0.0;

    conv_window_scheduler16 #(.img_height(4), .img_width(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
        .fmap_rd_en(frd4), .fmap_addr(faddr4), .fmap_data(fdata4),
        .weight_rd_en(wrd4), .weight_addr(waddr4), .weight_data(wdata4),
        .pe_floatA(fa4), .pe_floatB(fb4), .pe_conv_en(cen4),
        .pe_result(res4), .pe_out_valid(v4 | inj4),
        .out_we(owe4), .out_addr(oaddr4), .out_data(odata4)
    );

    // ---------------- DUT with default 8x8 feature map ----------------
    logic        start8 = 1'b0;
    logic        busy8, done8, frd8, wrd8, cen8, owe8;
    logic [7:0]  faddr8, waddr8, oaddr8;
    logic [15:0] fdata8 = '0, wdata8 = '0, fa8, fb8, odata8;
    logic [15:0] res8 = '0;
    logic        v8 = 1'b0;
    int          cnt8 = 0;
    real         acc8 = 0.0;

    conv_window_scheduler16 dut8 (
        .clk(clk), .reset(reset), .start(start8), .busy(busy8), .done(done8),
        .fmap_rd_en(frd8), .fmap_addr(faddr8), .fmap_data(fdata8),
        .weight_rd_en(wrd8), .weight_addr(waddr8), .weight_data(wdata8),
        .pe_floatA(fa8), .pe_floatB(fb8), .pe_conv_en(cen8),
        .pe_result(res8), .pe_out_valid(v8),
        .out_we(owe8), .out_addr(oaddr8), .out_data(odata8)
    );

    // fp16 <-> real for normal, exactly representable values
    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        m = 1.0 + real'(int'(h[9:0])) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        real m;
        int  e;
        if (r == 0.0) return 16'h0000;
        m = r;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {1'b0, 5'(e), 10'(int'((m - 1.0) * 1024.0))};
    endfunction

    // Synchronous RAMs, 1-cycle read latency
    always @(posedge clk) begin
        if (frd4) fdata4 <= fmem[faddr4];
        if (wrd4) wdata4 <= wmem[waddr4];
        if (frd8) fdata8 <= fmem[faddr8];
        if (wrd8) wdata8 <= wmem[waddr8];
    end

    // Behavioural PEs: S MACs, then a gap cycle with the result valid, then wrap
    always @(posedge clk) begin
        if (!cen4 || cnt4 == S) begin
            cnt4 <= 0; acc4 <= 0.0; v4 <= 1'b0;
        end else begin
            acc4 <= acc4 + h2r(fa4) * h2r(fb4);
            cnt4 <= cnt4 + 1;
            if (cnt4 == S - 1) begin
                res4 <= r2h(acc4 + h2r(fa4) * h2r(fb4));
                v4   <= 1'b1;
            end
        end
        if (!cen8 || cnt8 == S) begin
            cnt8 <= 0; acc8 <= 0.0; v8 <= 1'b0;
        end else begin
            acc8 <= acc8 + h2r(fa8) * h2r(fb8);
            cnt8 <= cnt8 + 1;
            if (cnt8 == S - 1) begin
                res8 <= r2h(acc8 + h2r(fa8) * h2r(fb8));
                v8   <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    wr_t wq4[$], wq8[$];
    rd_t rq4[$];
    int  wr_cnt4 = 0, wr_cnt8 = 0, done_cnt4 = 0, done_cnt8 = 0;
    int  len4 = 0, len8 = 0, last_len4 = 0, last_len8 = 0, runs4 = 0, runs8 = 0;

    initial begin
        wr_t e;
        rd_t r;
        forever begin
            @(negedge clk);
            if (owe4) begin
                wr_cnt4++;
                if (wq4.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut4 unexpected write: addr 0x%0h data 0x%0h at cycle %0d, none expected", oaddr4, odata4, cyc);
                end else begin
                    e = wq4.pop_front();
                    check("dut4 out_addr", 32'(oaddr4), 32'(e.addr));
                    check("dut4 out_data", 32'(odata4), 32'(e.data));
                    check("dut4 write cycle", cyc, e.cyc);
                end
            end
            if (frd4 && rq4.size() > 0) begin
                r = rq4.pop_front();
                check("dut4 fmap_addr", 32'(faddr4), 32'(r.faddr));
                check("dut4 weight_addr", 32'(waddr4), 32'(r.waddr));
                check("dut4 weight_rd_en", 32'(wrd4), 32'd1);
                check("dut4 read cycle", cyc, r.cyc);
            end
            if (cen4 && cnt4 == S) begin
                check("dut4 gap operand A", 32'(fa4), 32'h0);
                check("dut4 gap operand B", 32'(fb4), 32'h0);
            end
            if (done4) done_cnt4++;
            if (cen4) len4++;
            else if (len4 > 0) begin last_len4 = len4; runs4++; len4 = 0; end

            if (owe8) begin
                wr_cnt8++;
                if (wq8.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut8 unexpected write: addr 0x%0h data 0x%0h at cycle %0d, none expected", oaddr8, odata8, cyc);
                end else begin
                    e = wq8.pop_front();
                    check("dut8 out_addr", 32'(oaddr8), 32'(e.addr));
                    check("dut8 out_data", 32'(odata8), 32'(e.data));
                    check("dut8 write cycle", cyc, e.cyc);
                end
            end
            if (done8) done_cnt8++;
            if (cen8) len8++;
            else if (len8 > 0) begin last_len8 = len8; runs8++; len8 = 0; end
        end
    end

    // ---------------- stimulus ----------------
    // Hand-derived 4x4/K3 tables: window origin addresses and in-window offsets
    int          win_base [4] = '{0, 1, 4, 5};
    int          win_offs [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [15:0] exp4 [4];

    task automatic fill_ones();
        for (int i = 0; i < 64; i++) fmem[i] = FP16_ONE;
        for (int i = 0; i < 9; i++) wmem[i] = FP16_ONE;
    endtask

    task automatic check_idle4(input string tag);
        check({tag, " busy"}, 32'(busy4), 32'h0);
        check({tag, " done"}, 32'(done4), 32'h0);
        check({tag, " fmap_rd_en"}, 32'(frd4), 32'h0);
        check({tag, " weight_rd_en"}, 32'(wrd4), 32'h0);
        check({tag, " pe_conv_en"}, 32'(cen4), 32'h0);
        check({tag, " out_we"}, 32'(owe4), 32'h0);
        check({tag, " fmap_addr"}, 32'(faddr4), 32'h0);
        check({tag, " weight_addr"}, 32'(waddr4), 32'h0);
        check({tag, " pe_floatA"}, 32'(fa4), 32'h0);
        check({tag, " pe_floatB"}, 32'(fb4), 32'h0);
        check({tag, " out_addr"}, 32'(oaddr4), 32'h0);
        check({tag, " out_data"}, 32'(odata4), 32'h0);
    endtask

    task automatic run_dut4(input int restart_at);
        int t0, wr0, dn0, rn0;
        bit found;
        wr0 = wr_cnt4; dn0 = done_cnt4; rn0 = runs4;
        @(negedge clk);
        t0 = cyc + 1;
        for (int w = 0; w < 4; w++) begin
            wq4.push_back('{addr: 8'(w), data: exp4[w], cyc: t0 + w * 10 + 11});
            for (int k = 0; k < 9; k++)
                rq4.push_back('{faddr: 8'(win_base[w] + win_offs[k]), waddr: 8'(k), cyc: t0 + w * 10 + k});
        end
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("dut4 busy after start", 32'(busy4), 32'h1);
        check("dut4 first read slot", 32'(frd4), 32'h1);
        if (restart_at > 0) begin
            while (cyc < t0 + restart_at) @(negedge clk);
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (done4) found = 1'b1;
            else @(negedge clk);
        end
        check("dut4 done seen", 32'(found), 32'h1);
        if (found) begin
            check("dut4 done cycle", cyc, t0 + 42);
            check("dut4 busy low at done", 32'(busy4), 32'h0);
        end
        repeat (3) @(negedge clk);
        #1;
        check("dut4 write count", wr_cnt4 - wr0, 4);
        check("dut4 done pulses", done_cnt4 - dn0, 1);
        check("dut4 conv_en runs", runs4 - rn0, 1);
        check("dut4 conv_en length", last_len4, 40);
        check("dut4 writes outstanding", wq4.size(), 0);
        check("dut4 reads outstanding", rq4.size(), 0);
    endtask

    initial begin
        int t0, wr0, dn0, rn0;
        bit found;

        fill_ones();
        repeat (3) @(negedge clk);
        check_idle4("reset");
        check("reset dut8 busy", 32'(busy8), 32'h0);
        check("reset dut8 pe_conv_en", 32'(cen8), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // All-ones: every window sums nine 1.0 products = 9.0
        exp4 = '{16'h4880, 16'h4880, 16'h4880, 16'h4880};
        run_dut4(0);

        // A second start five cycles into the run must change nothing
        run_dut4(5);

        // pe_out_valid while idle must not write
        wr0 = wr_cnt4;
        inj4 = 1'b1;
        repeat (3) @(negedge clk);
        inj4 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("dut4 idle valid ignored", wr_cnt4 - wr0, 0);

        // Reset pulse in the middle of window 2: only windows 0 and 1 get written
        wr0 = wr_cnt4;
        @(negedge clk);
        t0 = cyc + 1;
        wq4.push_back('{addr: 8'd0, data: 16'h4880, cyc: t0 + 11});
        wq4.push_back('{addr: 8'd1, data: 16'h4880, cyc: t0 + 21});
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        while (cyc < t0 + 24) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_idle4("mid-run reset");
        repeat (30) @(negedge clk);
        #1;
        check("dut4 writes before reset", wr_cnt4 - wr0, 2);
        check("dut4 reset writes outstanding", wq4.size(), 0);
        check("dut4 idle after reset", 32'(busy4), 32'h0);
        run_dut4(0);

        // Centre-tap weight 2.0, pixel p = p+1: outputs 2*(centre+1) = 12, 14, 20, 22
        for (int i = 0; i < 16; i++) fmem[i] = r2h(real'(i + 1));
        for (int i = 0; i < 9; i++) wmem[i] = FP16_ZERO;
        wmem[4] = 16'h4000;
        exp4 = '{16'h4A00, 16'h4B00, 16'h4D00, 16'h4D80};
        run_dut4(0);

        // Default 8x8: 36 windows of 9.0, conv_en high for 360 cycles
        fill_ones();
        wr0 = wr_cnt8; dn0 = done_cnt8; rn0 = runs8;
        @(negedge clk);
        t0 = cyc + 1;
        for (int w = 0; w < 36; w++)
            wq8.push_back('{addr: 8'(w), data: 16'h4880, cyc: t0 + w * 10 + 11});
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("dut8 busy after start", 32'(busy8), 32'h1);
        check("dut8 first read address", 32'(faddr8), 32'h0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (done8) found = 1'b1;
            else @(negedge clk);
        end
        check("dut8 done seen", 32'(found), 32'h1);
        if (found) check("dut8 done cycle", cyc, t0 + 362);
        repeat (3) @(negedge clk);
        #1;
        check("dut8 write count", wr_cnt8 - wr0, 36);
        check("dut8 done pulses", done_cnt8 - dn0, 1);
        check("dut8 conv_en runs", runs8 - rn0, 1);
        check("dut8 conv_en length", last_len8, 360);
        check("dut8 writes outstanding", wq8.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
